// File: rtl/eth_ingress_buffer_pkg.sv
// Shared definitions for the ingress buffer and neighbouring reassembler blocks.
package eth_ingress_buffer_pkg;

    localparam int unsigned FLIT_DWIDTH   = 512;
    localparam int unsigned EMPTY_W       = 6;
    localparam int unsigned MAX_PKT_FLITS = 24;
    localparam int unsigned ING_DEPTH     = 512;
    localparam int unsigned ING_AWIDTH    = 9;

    typedef struct packed {
        logic [FLIT_DWIDTH-1:0] data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_W-1:0]     empty;
    } flit_entry_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RECV,
        WR_DROP
    } wr_state_t;

    function automatic int unsigned entry_width(input int unsigned dwidth, input int unsigned empty_w);
        return dwidth + 2 + empty_w;
    endfunction

endpackage

// File: rtl/eth_ingress_ram.sv
// Simple dual-port flit storage with registered read (maps to block RAM).
module eth_ingress_ram #(
    parameter int unsigned WIDTH  = 520,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned AWIDTH = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/eth_ingress_buffer.sv
// Store-and-forward ingress buffer: packets become visible downstream only once their EOP is stored.
module eth_ingress_buffer #(
    parameter int unsigned DWIDTH        = eth_ingress_buffer_pkg::FLIT_DWIDTH,
    parameter int unsigned EMPTY_W       = eth_ingress_buffer_pkg::EMPTY_W,
    parameter int unsigned DEPTH         = eth_ingress_buffer_pkg::ING_DEPTH,
    parameter int unsigned AWIDTH        = eth_ingress_buffer_pkg::ING_AWIDTH,
    parameter int unsigned MAX_PKT_FLITS = eth_ingress_buffer_pkg::MAX_PKT_FLITS
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               in_valid,
    input  logic [DWIDTH-1:0]  in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DWIDTH-1:0]  out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic [31:0]        fill_level,
    output logic [31:0]        stats_pkt_in,
    output logic [31:0]        stats_pkt_out,
    output logic [31:0]        stats_drop_full,
    output logic [31:0]        stats_drop_err
);

    import eth_ingress_buffer_pkg::*;

    localparam int unsigned PW    = AWIDTH + 1;
    localparam int unsigned EW    = entry_width(DWIDTH, EMPTY_W);
    localparam int unsigned CNT_W = $clog2(MAX_PKT_FLITS + 1);

    wr_state_t          state, state_next;
    logic [PW-1:0]      wr_ptr, wr_next;
    logic [PW-1:0]      commit_ptr, commit_next;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      sop_base;
    logic [PW-1:0]      base_used;
    logic [PW:0]        base_free;
    logic [PW-1:0]      used_now;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               do_sop;
    logic               we;
    logic [AWIDTH-1:0]  waddr;
    logic               pkt_in_inc, drop_full_inc, drop_err_inc;

    logic               re;
    logic               rd_pending;
    logic [EW-1:0]      rdata;
    logic [EW-1:0]      q0, q1;
    logic               v0, v1;
    logic               pop;
    logic [1:0]         slots;

    // ---------------- write side ----------------

    always_comb begin
        state_next    = state;
        wr_next       = wr_ptr;
        commit_next   = commit_ptr;
        cnt_next      = cnt;
        we            = 1'b0;
        waddr         = wr_ptr[AWIDTH-1:0];
        pkt_in_inc    = 1'b0;
        drop_full_inc = 1'b0;
        drop_err_inc  = 1'b0;
        do_sop        = 1'b0;
        sop_base      = wr_ptr;

        if (in_valid) begin
            unique case (state)
                WR_IDLE: begin
                    if (in_sop) begin
                        do_sop = 1'b1;
                    end else if (in_eop) begin
                        drop_err_inc = 1'b1;
                    end
                end
                WR_RECV: begin
                    if (in_sop) begin
                        // Abandon the partial packet, then admit the new one against the rolled-back pointer.
                        drop_err_inc = 1'b1;
                        do_sop       = 1'b1;
                        sop_base     = commit_ptr;
                    end else if (cnt == CNT_W'(MAX_PKT_FLITS)) begin
                        wr_next      = commit_ptr;
                        drop_err_inc = 1'b1;
                        state_next   = in_eop ? WR_IDLE : WR_DROP;
                    end else begin
                        we       = 1'b1;
                        wr_next  = wr_ptr + PW'(1);
                        cnt_next = cnt + CNT_W'(1);
                        if (in_eop) begin
                            commit_next = wr_ptr + PW'(1);
                            pkt_in_inc  = 1'b1;
                            state_next  = WR_IDLE;
                        end
                    end
                end
                WR_DROP: begin
                    if (in_sop) begin
                        do_sop = 1'b1;
                    end else if (in_eop) begin
                        state_next = WR_IDLE;
                    end
                end
                default: state_next = WR_IDLE;
            endcase
        end

        base_used = sop_base - rd_ptr;
        base_free = (PW+1)'(DEPTH) - {1'b0, base_used};

        if (do_sop) begin
            if (base_free >= (PW+1)'(MAX_PKT_FLITS)) begin
                we       = 1'b1;
                waddr    = sop_base[AWIDTH-1:0];
                wr_next  = sop_base + PW'(1);
                cnt_next = CNT_W'(1);
                if (in_eop) begin
                    commit_next = sop_base + PW'(1);
                    pkt_in_inc  = 1'b1;
                    state_next  = WR_IDLE;
                end else begin
                    state_next = WR_RECV;
                end
            end else begin
                drop_full_inc = 1'b1;
                wr_next       = sop_base;
                state_next    = in_eop ? WR_IDLE : WR_DROP;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_next;
            commit_ptr <= commit_next;
            cnt        <= cnt_next;
        end
    end

    eth_ingress_ram #(
        .WIDTH  (EW),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk   (Clk),
        .we    (we),
        .waddr (waddr),
        .wdata ({in_data, in_sop, in_eop, in_empty}),
        .re    (re),
        .raddr (rd_ptr[AWIDTH-1:0]),
        .rdata (rdata)
    );

    // ---------------- read side ----------------

    // A read is issued only if the 2-entry output queue can absorb it when it lands next cycle.
    assign pop   = v0 & out_ready;
    assign slots = {1'b0, v0} + {1'b0, v1} + {1'b0, rd_pending} - {1'b0, pop};
    assign re    = (rd_ptr != commit_ptr) && (slots < 2'd2);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
            v0         <= 1'b0;
            v1         <= 1'b0;
            q0         <= '0;
            q1         <= '0;
        end else begin
            rd_pending <= re;
            if (re) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({pop, rd_pending})
                2'b10: begin
                    q0 <= q1;
                    v0 <= v1;
                    v1 <= 1'b0;
                end
                2'b01: begin
                    if (!v0) begin
                        q0 <= rdata;
                        v0 <= 1'b1;
                    end else begin
                        q1 <= rdata;
                        v1 <= 1'b1;
                    end
                end
                2'b11: begin
                    if (v1) begin
                        q0 <= q1;
                        q1 <= rdata;
                    end else begin
                        q0 <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid                                = v0;
    assign {out_data, out_sop, out_eop, out_empty} = q0;

    assign used_now   = wr_ptr - rd_ptr;
    assign fill_level = {{(32-PW){1'b0}}, used_now};

    // ---------------- statistics ----------------

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stats_pkt_in    <= '0;
            stats_pkt_out   <= '0;
            stats_drop_full <= '0;
            stats_drop_err  <= '0;
        end else begin
            if (pkt_in_inc) begin
                stats_pkt_in <= stats_pkt_in + 32'd1;
            end
            if (pop && out_eop) begin
                stats_pkt_out <= stats_pkt_out + 32'd1;
            end
            if (drop_full_inc) begin
                stats_drop_full <= stats_drop_full + 32'd1;
            end
            if (drop_err_inc) begin
                stats_drop_err <= stats_drop_err + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_ingress_buffer.sv
// Scoreboard bench for eth_ingress_buffer: packet-level reference model feeds an expected-flit queue.
module tb_eth_ingress_buffer;

    import eth_ingress_buffer_pkg::*;

    localparam int unsigned DW    = FLIT_DWIDTH;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned MAXF  = MAX_PKT_FLITS;

    logic               Clk = 1'b0;
    logic               Rst;
    logic               in_valid;
    logic [DW-1:0]      in_data;
    logic               in_sop;
    logic               in_eop;
    logic [EMPTY_W-1:0] in_empty;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic               out_sop;
    logic               out_eop;
    logic [EMPTY_W-1:0] out_empty;
    logic [31:0]        fill_level;
    logic [31:0]        stats_pkt_in;
    logic [31:0]        stats_pkt_out;
    logic [31:0]        stats_drop_full;
    logic [31:0]        stats_drop_err;

    always #5 Clk = ~Clk;

    eth_ingress_buffer #(
        .DWIDTH        (DW),
        .EMPTY_W       (EMPTY_W),
        .DEPTH         (DEPTH),
        .AWIDTH        (9),
        .MAX_PKT_FLITS (MAXF)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_sop          (in_sop),
        .in_eop          (in_eop),
        .in_empty        (in_empty),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_empty       (out_empty),
        .fill_level      (fill_level),
        .stats_pkt_in    (stats_pkt_in),
        .stats_pkt_out   (stats_pkt_out),
        .stats_drop_full (stats_drop_full),
        .stats_drop_err  (stats_drop_err)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    flit_entry_t expq[$];
    flit_entry_t cur[$];
    int unsigned pop_cyc[$];
    int unsigned stored  = 0;
    bit          in_pkt  = 1'b0;
    bit          discard = 1'b0;
    bit          rnd_ready = 1'b0;
    int unsigned m_in = 0, m_out = 0, m_full = 0, m_err = 0;
    int unsigned cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------

    task automatic commit_cur();
        foreach (cur[i]) expq.push_back(cur[i]);
        stored += cur.size();
        m_in++;
        cur.delete();
        in_pkt = 1'b0;
    endtask

    task automatic model_apply(input flit_entry_t f);
        if (f.sop) begin
            if (in_pkt) m_err++;
            cur.delete();
            in_pkt  = 1'b0;
            discard = 1'b0;
            if (DEPTH - stored >= MAXF) begin
                in_pkt = 1'b1;
                cur.push_back(f);
                if (f.eop) commit_cur();
            end else begin
                m_full++;
                discard = !f.eop;
            end
        end else if (in_pkt) begin
            if (cur.size() == MAXF) begin
                m_err++;
                in_pkt = 1'b0;
                cur.delete();
                discard = !f.eop;
            end else begin
                cur.push_back(f);
                if (f.eop) commit_cur();
            end
        end else if (discard) begin
            if (f.eop) discard = 1'b0;
        end else if (f.eop) begin
            m_err++;
        end
    endtask

    task automatic model_reset();
        expq.delete();
        cur.delete();
        stored  = 0;
        in_pkt  = 1'b0;
        discard = 1'b0;
        m_in = 0; m_out = 0; m_full = 0; m_err = 0;
    endtask

    // ---------------- monitor ----------------

    always @(negedge Clk) begin
        flit_entry_t got, e;
        if (!Rst && out_valid && out_ready) begin
            checks++;
            got = '{data: out_data, sop: out_sop, eop: out_eop, empty: out_empty};
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_flit actual=sop%0b/eop%0b/empty%0d required=no_output", out_sop, out_eop, out_empty);
            end else begin
                e = expq.pop_front();
                if (got != e) begin
                    failures++;
                    $display("FAIL flit actual=%h required=%h", got, e);
                end
                if (e.eop) m_out++;
                stored--;
                pop_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick_tail();
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_flit(input bit sop, input bit eop, input logic [EMPTY_W-1:0] emp);
        flit_entry_t f;
        f = '{data: rand_data(), sop: sop, eop: eop, empty: emp};
        in_valid = 1'b1;
        in_data  = f.data;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = emp;
        @(posedge Clk);
        if (!Rst) model_apply(f);
        #1;
        in_valid = 1'b0;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_pkt(input int unsigned len);
        for (int unsigned i = 0; i < len; i++)
            send_flit(i == 0, i == len - 1, (i == len - 1) ? EMPTY_W'($urandom_range(0, 63)) : '0);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge Clk);
            tick_tail();
        end
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned k = 0;
        out_ready = 1'b1;
        while ((expq.size() != 0 || out_valid) && k < budget) begin
            @(posedge Clk);
            #1;
            k++;
        end
        if (k >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout actual=%0d_pending required=0", name, expq.size());
        end
    endtask

    task automatic check_counters(input string name);
        check({name, "_pkt_in"},    stats_pkt_in,    m_in);
        check({name, "_pkt_out"},   stats_pkt_out,   m_out);
        check({name, "_drop_full"}, stats_drop_full, m_full);
        check({name, "_drop_err"},  stats_drop_err,  m_err);
        check({name, "_fill"},      fill_level,      stored);
    endtask

    // ---------------- test sequence ----------------

    initial begin
        int unsigned idx0, span;
        Rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data_zero", (out_data == '0), 1);
        check_counters("rst");
        Rst = 1'b0;
        idle(2);

        // 1) single-flit packet and its latency
        send_flit(1'b1, 1'b1, EMPTY_W'(10));
        check("t1_pkt_in_at_eop_edge", stats_pkt_in, 1);
        idle(1);
        check("t1_valid_edge_n1", out_valid, 0);
        idle(1);
        check("t1_valid_edge_n2", out_valid, 1);
        check("t1_empty", out_empty, 10);
        wait_drain("t1", 50);
        check_counters("t1");

        // 2) 100 back-to-back max-size packets
        idx0 = pop_cyc.size();
        repeat (100) send_pkt(MAXF);
        wait_drain("t2", 3000);
        check("t2_flit_count", pop_cyc.size() - idx0, 2400);
        span = (pop_cyc.size() >= idx0 + 2400) ? pop_cyc[idx0 + 2399] - pop_cyc[idx0] : 0;
        check("t2_gapless_span", span, 2399);
        check_counters("t2");

        // 3) oversize packet rolled back
        check("t3_fill_before", fill_level, stored);
        for (int unsigned i = 0; i < MAXF; i++) send_flit(i == 0, 1'b0, '0);
        check("t3_fill_mid", fill_level, stored + cur.size());
        send_flit(1'b0, 1'b1, EMPTY_W'(5));
        check("t3_fill_after", fill_level, stored);
        send_pkt(5);
        wait_drain("t3", 100);
        check_counters("t3");

        // 4) sop arriving at flit 3 of a packet
        send_flit(1'b1, 1'b0, '0);
        send_flit(1'b0, 1'b0, '0);
        send_flit(1'b0, 1'b0, '0);
        send_pkt(6);
        wait_drain("t4", 100);
        check_counters("t4");

        // random mix with a stalling consumer
        rnd_ready = 1'b1;
        for (int n = 0; n < 80; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind <= 5)      send_pkt($urandom_range(1, MAXF));
            else if (kind == 6) send_pkt($urandom_range(MAXF + 1, MAXF + 4));
            else if (kind == 7) for (int unsigned i = 0; i < $urandom_range(1, 4); i++) send_flit(i == 0, 1'b0, '0);
            else if (kind == 8) send_flit(1'b0, 1'(($urandom_range(0, 1))), '0);
            else                send_pkt(MAXF);
            idle($urandom_range(0, 2));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        send_pkt(3);
        wait_drain("rand", 3000);
        check_counters("rand");

        // 5) fill until admission fails
        out_ready = 1'b0;
        repeat (21) send_pkt(MAXF);
        idle(3);
        check("t5_fill_ge_490", (fill_level >= 490), 1);
        check("t5_fill_near_model", (fill_level <= stored && fill_level + 3 >= stored), 1);
        send_pkt(MAXF);
        check("t5_drop_full", stats_drop_full, m_full);
        wait_drain("t5", 1000);
        check_counters("t5");

        // 6) reset mid-receive and mid-output
        out_ready = 1'b0;
        repeat (3) send_pkt(4);
        idle(4);
        check("t6_holding_output", out_valid, 1);
        send_flit(1'b1, 1'b0, '0);
        send_flit(1'b0, 1'b0, '0);
        #2;
        Rst = 1'b1;
        #1;
        model_reset();
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data_zero", (out_data == '0), 1);
        check_counters("t6_rst");
        send_flit(1'b1, 1'b1, '0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        out_ready = 1'b1;
        send_flit(1'b0, 1'b0, '0);
        send_flit(1'b0, 1'b1, EMPTY_W'(3));
        send_pkt(3);
        wait_drain("t6", 100);
        check_counters("t6");
        check("t6_orphan_err", stats_drop_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
